cargador_mascara: RTL and testbench

CARGADOR_MASCARA -- requirements
Module: cargador_mascara

---
 rtl/cargador_mascara.sv | 140 ++++++++++++++
 tb/tb_cargador_mascara.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/cargador_mascara.sv
// Mask loader: streams N = 9 or 25 coefficients from memory into a coefficient bank.
// Optional coefficient accumulator enabled by macro CARGADOR_MASCARA_SUMA_EN.
module cargador_mascara #(
  parameter int BITS_DIRECCION_MEM = 10,
  parameter int BITS_DATOS         = 8,
  parameter int BITS_MASCARA       = 3
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          inicio,
  input  logic [BITS_DIRECCION_MEM-1:0] direccion_inicio,
  input  logic [BITS_MASCARA-1:0]       tamano_mascara,
  output logic [BITS_DIRECCION_MEM-1:0] mem_direccion,
  output logic                          mem_lectura,
  input  logic [BITS_DATOS-1:0]         mem_datos,
  output logic                          coef_escritura,
  output logic [4:0]                    coef_indice,
  output logic [BITS_DATOS-1:0]         coef_datos,
  output logic                          ocupado,
  output logic                          mascara_lista,
  output logic                          error_tamano,
  output logic [BITS_DATOS+4:0]         suma_coeficientes,
  output logic [1:0]                    o_estado
);

  // Handshake: a read issued in cycle c (mem_lectura=1) returns mem_datos in cycle c+1,
  // which is exactly the cycle coef_escritura is high for that read; there is no back-pressure.
  typedef enum logic [1:0] {
    REPOSO = 2'd0,
    LEER   = 2'd1,
    DRENAR = 2'd2,
    LISTO  = 2'd3
  } estado_t;

  estado_t                       r_estado;
  logic [BITS_DIRECCION_MEM-1:0] r_dir;
  logic                          r_lectura;
  logic [4:0]                    r_idx;
  logic [4:0]                    r_ultimo;
  logic                          r_escritura;
  logic [4:0]                    r_coef_idx;
  logic                          r_ocupado;
  logic                          r_lista;
  logic                          r_error;

  logic                          w_tam_ok;
  logic [4:0]                    w_ultimo;

  assign w_tam_ok = (tamano_mascara == BITS_MASCARA'(3)) ||
                    (tamano_mascara == BITS_MASCARA'(5));
  assign w_ultimo = (tamano_mascara == BITS_MASCARA'(5)) ? 5'd24 : 5'd8;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado    <= REPOSO;
      r_dir       <= '0;
      r_lectura   <= 1'b0;
      r_idx       <= '0;
      r_ultimo    <= '0;
      r_escritura <= 1'b0;
      r_coef_idx  <= '0;
      r_ocupado   <= 1'b0;
      r_lista     <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_error     <= 1'b0;
      r_escritura <= 1'b0;
      r_coef_idx  <= '0;
      if (inicio) begin
        // A new request always wins; the write of the read in flight is dropped.
        if (w_tam_ok) begin
          r_estado  <= LEER;
          r_dir     <= direccion_inicio;
          r_lectura <= 1'b1;
          r_idx     <= '0;
          r_ultimo  <= w_ultimo;
          r_ocupado <= 1'b1;
          r_lista   <= 1'b0;
        end else begin
          r_estado  <= REPOSO;
          r_lectura <= 1'b0;
          r_ocupado <= 1'b0;
          r_lista   <= 1'b0;
          r_error   <= 1'b1;
        end
      end else begin
        r_escritura <= r_lectura;
        r_coef_idx  <= r_lectura ? r_idx : 5'd0;
        case (r_estado)
          LEER: begin
            if (r_idx == r_ultimo) begin
              r_lectura <= 1'b0;
              r_estado  <= DRENAR;
            end else begin
              r_idx <= r_idx + 5'd1;
              r_dir <= r_dir + 1'b1;
            end
          end
          DRENAR: begin
            r_estado  <= LISTO;
            r_ocupado <= 1'b0;
            r_lista   <= 1'b1;
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign mem_direccion  = r_dir;
  assign mem_lectura    = r_lectura;
  assign coef_escritura = r_escritura;
  assign coef_indice    = r_coef_idx;
  assign coef_datos     = mem_datos;
  assign ocupado        = r_ocupado;
  assign mascara_lista  = r_lista;
  assign error_tamano   = r_error;
  assign o_estado       = r_estado;

`ifdef CARGADOR_MASCARA_SUMA_EN
  logic [BITS_DATOS+4:0] r_suma;

  // The last write lands on the same edge mascara_lista rises, so the total is valid with it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_suma <= '0;
    end else if (inicio && w_tam_ok) begin
      r_suma <= '0;
    end else if (r_escritura) begin
      r_suma <= r_suma + {5'd0, mem_datos};
    end
  end

  assign suma_coeficientes = r_suma;
`else
  assign suma_coeficientes = '0;
`endif

endmodule

// File: tb/tb_cargador_mascara.sv
// Bench for cargador_mascara: directed scenarios plus random loads, restarts and resets,
// checked cycle by cycle against a queue-based reference model.
module tb_cargador_mascara;
  localparam int AW = 10;
  localparam int DW = 8;
  localparam int MW = 3;
  localparam int NUNCA = 32'h7fffffff;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          inicio = 1'b0;
  logic [AW-1:0] direccion_inicio = '0;
  logic [MW-1:0] tamano_mascara = '0;
  logic [AW-1:0] mem_direccion;
  logic          mem_lectura;
  logic [DW-1:0] mem_datos;
  logic          coef_escritura;
  logic [4:0]    coef_indice;
  logic [DW-1:0] coef_datos;
  logic          ocupado;
  logic          mascara_lista;
  logic          error_tamano;
  logic [DW+4:0] suma_coeficientes;
  logic [1:0]    o_estado;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  cargador_mascara #(
    .BITS_DIRECCION_MEM(AW),
    .BITS_DATOS(DW),
    .BITS_MASCARA(MW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .inicio(inicio),
    .direccion_inicio(direccion_inicio),
    .tamano_mascara(tamano_mascara),
    .mem_direccion(mem_direccion),
    .mem_lectura(mem_lectura),
    .mem_datos(mem_datos),
    .coef_escritura(coef_escritura),
    .coef_indice(coef_indice),
    .coef_datos(coef_datos),
    .ocupado(ocupado),
    .mascara_lista(mascara_lista),
    .error_tamano(error_tamano),
    .suma_coeficientes(suma_coeficientes),
    .o_estado(o_estado)
  );

  // Memory: one-cycle read latency
  logic [DW-1:0] mem [0:1023];
  always @(posedge clk) mem_datos <= mem[mem_direccion];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail = 0;

  logic [41:0] rd_q[$];   // {cycle, address}
  logic [44:0] wr_q[$];   // {cycle, index, data}
  int          busy_lo = 1;
  int          busy_hi = 0;
  int          lista_from = NUNCA;
  int          err_cyc = -1;
  logic [12:0] exp_sum = '0;
  logic [41:0] e_rd;
  logic [44:0] e_wr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", nm, cyc, act, exp);
    end
  endtask

  // Monitor: samples DUT outputs on the falling edge
  always @(negedge clk) begin
    if (rd_q.size() > 0 && !mem_lectura && int'(rd_q[0][41:10]) <= cyc) begin
      chk("read_missing", 32'(mem_lectura), 32'd1);
      void'(rd_q.pop_front());
    end
    if (mem_lectura) begin
      if (rd_q.size() == 0) chk("read_unexpected", 32'(mem_lectura), 32'd0);
      else begin
        e_rd = rd_q.pop_front();
        chk("read_cycle", cyc, e_rd[41:10]);
        chk("read_addr", 32'(mem_direccion), 32'(e_rd[9:0]));
      end
    end
    if (wr_q.size() > 0 && !coef_escritura && int'(wr_q[0][44:13]) <= cyc) begin
      chk("write_missing", 32'(coef_escritura), 32'd1);
      void'(wr_q.pop_front());
    end
    if (coef_escritura) begin
      if (wr_q.size() == 0) chk("write_unexpected", 32'(coef_escritura), 32'd0);
      else begin
        e_wr = wr_q.pop_front();
        chk("write_cycle", cyc, e_wr[44:13]);
        chk("write_idx", 32'(coef_indice), 32'(e_wr[12:8]));
        chk("write_data", 32'(coef_datos), 32'(e_wr[7:0]));
      end
    end else begin
      chk("coef_indice_idle", 32'(coef_indice), 32'd0);
    end
    chk("ocupado", 32'(ocupado), 32'(cyc >= busy_lo && cyc <= busy_hi));
    chk("mascara_lista", 32'(mascara_lista), 32'(cyc >= lista_from));
    chk("error_tamano", 32'(error_tamano), 32'(cyc == err_cyc));
`ifdef CARGADOR_MASCARA_SUMA_EN
    if (cyc == lista_from) chk("suma", 32'(suma_coeficientes), 32'(exp_sum));
`else
    chk("suma_zero", 32'(suma_coeficientes), 32'd0);
`endif
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Call right after step(); the request is sampled at the next rising edge k.
  task automatic issue(input logic [AW-1:0] base, input logic [MW-1:0] tam);
    int k;
    int n;
    logic [AW-1:0] a;
    logic [12:0] s;
    inicio = 1'b1;
    direccion_inicio = base;
    tamano_mascara = tam;
    k = cyc + 1;
    rd_q.delete();
    wr_q.delete();
    if (tam == 3 || tam == 5) begin
      n = int'(tam) * int'(tam);
      s = '0;
      for (int i = 0; i < n; i++) begin
        a = base + AW'(i);
        rd_q.push_back({32'(k + i), a});
        wr_q.push_back({32'(k + i + 1), 5'(i), mem[a]});
        s = s + 13'(mem[a]);
      end
      busy_lo = k;
      busy_hi = k + n;
      lista_from = k + n + 1;
      exp_sum = s;
    end else begin
      busy_lo = 1;
      busy_hi = 0;
      lista_from = NUNCA;
      err_cyc = k;
    end
    @(posedge clk);
    #1;
    inicio = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_mem_lectura", 32'(mem_lectura), 32'd0);
    chk("rst_coef_escritura", 32'(coef_escritura), 32'd0);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_mascara_lista", 32'(mascara_lista), 32'd0);
    chk("rst_error_tamano", 32'(error_tamano), 32'd0);
    chk("rst_mem_direccion", 32'(mem_direccion), 32'd0);
    chk("rst_coef_indice", 32'(coef_indice), 32'd0);
    chk("rst_suma", 32'(suma_coeficientes), 32'd0);
    chk("rst_estado", 32'(o_estado), 32'd0);
  endtask

  // Call right after step(); reset is sampled at the next rising edge.
  task automatic do_reset();
    reset = 1'b1;
    rd_q.delete();
    wr_q.delete();
    busy_lo = 1;
    busy_hi = 0;
    lista_from = NUNCA;
    err_cyc = -1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk_reset_outputs();
    #1;
  endtask

  // ---------------- stimulus ----------------
  int nb;
  int sel;
  int act;
  logic [MW-1:0] tam_r;

  initial begin
    for (int a = 0; a < 1024; a++) mem[a] = 8'(a);
    step();
    step();
    chk_reset_outputs();
    reset = 1'b0;
    step();

    // Size 3 from 0x040, data = address low bits
    issue(10'h040, 3'd3);
    repeat (14) step();
`ifdef CARGADOR_MASCARA_SUMA_EN
    chk("suma_612", 32'(suma_coeficientes), 32'd612);
`endif

    // Size 5 wrapping past the top of memory
    issue(10'h3F0, 3'd5);
    nb = 0;
    repeat (30) begin
      step();
      nb += int'(ocupado);
    end
    chk("ocupado_cycles", nb, 32'd26);

    // Illegal size
    issue(10'h123, 3'd4);
    step();
    step();
    chk("err_estado_reposo", 32'(o_estado), 32'd0);
    chk("err_lista_low", 32'(mascara_lista), 32'd0);
    repeat (3) step();

    // Size 5 restarted at read index 7 by a size-3 request
    issue(10'h200, 3'd5);
    repeat (8) step();
    issue(10'h100, 3'd3);
    repeat (14) step();

    // Reset at read index 4
    issue(10'h080, 3'd3);
    repeat (5) step();
    do_reset();
    repeat (5) step();

    // Random phase: new memory contents, mixed sizes, interruptions and resets
    for (int a = 0; a < 1024; a++) mem[a] = 8'($urandom_range(0, 255));
    for (int it = 0; it < 25; it++) begin
      sel = $urandom_range(0, 9);
      tam_r = (sel < 4) ? 3'd3 : (sel < 8) ? 3'd5 : 3'($urandom_range(0, 7));
      issue(10'($urandom_range(0, 1023)), tam_r);
      act = $urandom_range(0, 9);
      if (act < 6) begin
        repeat (30) step();
      end else if (act < 8) begin
        repeat ($urandom_range(1, 20)) step();
      end else begin
        repeat ($urandom_range(1, 10)) step();
        do_reset();
        step();
      end
    end
    repeat (30) step();

    chk("rd_q_drained", 32'(rd_q.size()), 32'd0);
    chk("wr_q_drained", 32'(wr_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
